// File: rtl/ctrl_flow_unit.sv
// IF/ID pipeline register plus ID-stage control-flow resolver (branches, jumps, SIIC/RTI, HALT).
// Optional CFU_STATS_EN adds saturating TakenCount/SquashCount statistics outputs.
module ctrl_flow_unit #(
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter int unsigned STATS_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Instr,
    input  logic [15:0] IncPC,
    input  logic [15:0] RsData,
    output logic [2:0]  RsAddr,
    output logic [15:0] BranchPC,
    output logic        BranchJumpTaken,
    output logic        Halt,
    output logic        Rti,
    output logic        Exception,
    output logic [15:0] IdInstr,
    output logic [15:0] IdIncPC,
    output logic        IdValid,
    output logic        Halted
`ifdef CFU_STATS_EN
    ,
    output logic [STATS_W-1:0] TakenCount,
    output logic [STATS_W-1:0] SquashCount
`endif
);

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_SIIC = 5'b00010;
    localparam logic [4:0] OP_RTI  = 5'b00011;
    localparam logic [4:0] OP_J    = 5'b00100;
    localparam logic [4:0] OP_JR   = 5'b00101;
    localparam logic [4:0] OP_JAL  = 5'b00110;
    localparam logic [4:0] OP_JALR = 5'b00111;
    localparam logic [4:0] OP_BEQZ = 5'b01100;
    localparam logic [4:0] OP_BNEZ = 5'b01101;
    localparam logic [4:0] OP_BLTZ = 5'b01110;
    localparam logic [4:0] OP_BGEZ = 5'b01111;

    if (STATS_W == 0) begin : g_stats_w_invalid
        $error("ctrl_flow_unit: STATS_W must be nonzero");
    end

    typedef enum logic [1:0] {
        ST_RUN,
        ST_EXCPT,
        ST_HALTED
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] id_instr_q, id_inc_pc_q;
    logic        id_valid_q;

    logic [4:0]  opcode;
    logic [15:0] sext_imm8, sext_d11;
    logic        taken_c, halt_c, rti_c, exc_c, halted_c, sq_c;

    assign opcode    = id_instr_q[15:11];
    assign sext_imm8 = {{8{id_instr_q[7]}}, id_instr_q[7:0]};
    assign sext_d11  = {{5{id_instr_q[10]}}, id_instr_q[10:0]};

    // Redirect target is formed every cycle; only the taken flag is qualified.
    always_comb begin
        BranchPC = id_inc_pc_q + sext_imm8;
        case (opcode)
            OP_J, OP_JAL:   BranchPC = id_inc_pc_q + sext_d11;
            OP_JR, OP_JALR: BranchPC = RsData + sext_imm8;
            default:        ;
        endcase
    end

    // Next-state and control pulses; HALTED holds Halt regardless of ID contents.
    always_comb begin
        state_d  = state_q;
        taken_c  = 1'b0;
        halt_c   = 1'b0;
        rti_c    = 1'b0;
        exc_c    = 1'b0;
        halted_c = 1'b0;
        if (state_q == ST_HALTED) begin
            halt_c   = 1'b1;
            halted_c = 1'b1;
        end else if (id_valid_q) begin
            case (opcode)
                OP_J, OP_JAL, OP_JR, OP_JALR: taken_c = 1'b1;
                OP_BEQZ: taken_c = (RsData == 16'h0000);
                OP_BNEZ: taken_c = (RsData != 16'h0000);
                OP_BLTZ: taken_c = RsData[15];
                OP_BGEZ: taken_c = ~RsData[15];
                OP_SIIC: begin
                    if (state_q == ST_RUN) begin
                        exc_c   = 1'b1;
                        state_d = ST_EXCPT;
                    end
                end
                OP_RTI: begin
                    if (state_q == ST_EXCPT) begin
                        rti_c   = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                OP_HALT: begin
                    halt_c  = 1'b1;
                    state_d = ST_HALTED;
                end
                default: ;
            endcase
        end
    end

    assign sq_c = taken_c | exc_c | rti_c | halt_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            id_instr_q  <= NOP_INSTR;
            id_inc_pc_q <= 16'h0000;
            id_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_inc_pc_q <= IncPC;
            id_instr_q  <= sq_c ? NOP_INSTR : Instr;
            id_valid_q  <= ~sq_c;
        end
    end

`ifdef CFU_STATS_EN
    logic [STATS_W-1:0] taken_cnt_q, squash_cnt_q;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            if (taken_c && (taken_cnt_q != '1))
                taken_cnt_q <= taken_cnt_q + STATS_W'(1);
            if (sq_c && (squash_cnt_q != '1))
                squash_cnt_q <= squash_cnt_q + STATS_W'(1);
        end
    end

    assign TakenCount  = taken_cnt_q;
    assign SquashCount = squash_cnt_q;
`endif

    assign RsAddr          = id_instr_q[10:8];
    assign BranchJumpTaken = taken_c;
    assign Halt            = halt_c;
    assign Rti             = rti_c;
    assign Exception       = exc_c;
    assign Halted          = halted_c;
    assign IdInstr         = id_instr_q;
    assign IdIncPC         = id_inc_pc_q;
    assign IdValid         = id_valid_q;

endmodule

// File: tb/tb_ctrl_flow_unit.sv
// Directed self-checking bench for ctrl_flow_unit; stats checks compile in with CFU_STATS_EN.
module tb_ctrl_flow_unit;

    localparam int unsigned STATS_W = 4;

    logic        clk;
    logic        rst;
    logic [15:0] Instr, IncPC, RsData;
    logic [2:0]  RsAddr;
    logic [15:0] BranchPC, IdInstr, IdIncPC;
    logic        BranchJumpTaken, Halt, Rti, Exception, IdValid, Halted;
`ifdef CFU_STATS_EN
    logic [STATS_W-1:0] TakenCount, SquashCount;
`endif

    int n_cmp = 0;
    int n_err = 0;

    ctrl_flow_unit #(.NOP_INSTR(16'h0800), .STATS_W(STATS_W)) dut (
        .clk(clk), .rst(rst), .Instr(Instr), .IncPC(IncPC), .RsData(RsData),
        .RsAddr(RsAddr), .BranchPC(BranchPC), .BranchJumpTaken(BranchJumpTaken),
        .Halt(Halt), .Rti(Rti), .Exception(Exception), .IdInstr(IdInstr),
        .IdIncPC(IdIncPC), .IdValid(IdValid), .Halted(Halted)
`ifdef CFU_STATS_EN
        , .TakenCount(TakenCount), .SquashCount(SquashCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next posedge; outputs sampled 1ns later via settle delays.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctrl(input string tag, input logic bjt, input logic hlt,
                              input logic rt, input logic exc, input logic hd);
        check_eq({tag, ".taken"}, 32'(BranchJumpTaken), 32'(bjt));
        check_eq({tag, ".halt"},  32'(Halt),            32'(hlt));
        check_eq({tag, ".rti"},   32'(Rti),             32'(rt));
        check_eq({tag, ".exc"},   32'(Exception),       32'(exc));
        check_eq({tag, ".halted"},32'(Halted),          32'(hd));
    endtask

    initial begin
        rst = 1'b1; Instr = 16'h61FE; IncPC = 16'h0010; RsData = 16'h0000;
        tick(); tick();
        check_eq("rst.valid", 32'(IdValid), 32'd0);
        check_eq("rst.instr", 32'(IdInstr), 32'h0800);
        check_eq("rst.incpc", 32'(IdIncPC), 32'h0000);
        check_ctrl("rst", 0, 0, 0, 0, 0);

        rst = 1'b0; #1;
        check_eq("rst_drop.valid", 32'(IdValid), 32'd0);

        // BEQZ taken with RsData=0
        tick();
        check_eq("beqz.instr", 32'(IdInstr), 32'h61FE);
        check_eq("beqz.valid", 32'(IdValid), 32'd1);
        check_eq("beqz.rsaddr", 32'(RsAddr), 32'd1);
        check_eq("beqz.bpc", 32'(BranchPC), 32'h000E);
        check_ctrl("beqz", 1, 0, 0, 0, 0);
        Instr = 16'h69FE; IncPC = 16'h0012;
        tick();
        check_eq("beqz_sq.valid", 32'(IdValid), 32'd0);
        check_eq("beqz_sq.instr", 32'(IdInstr), 32'h0800);
        check_eq("beqz_sq.incpc", 32'(IdIncPC), 32'h0012);
        check_ctrl("beqz_sq", 0, 0, 0, 0, 0);

        // BNEZ not taken, then BLTZ taken on negative operand
        IncPC = 16'h0020;
        tick();
        check_eq("bnez.instr", 32'(IdInstr), 32'h69FE);
        check_ctrl("bnez", 0, 0, 0, 0, 0);
        Instr = 16'h71FE; IncPC = 16'h0030;
        tick();
        check_eq("bltz.valid", 32'(IdValid), 32'd1);
        check_eq("bltz.instr", 32'(IdInstr), 32'h71FE);
        RsData = 16'h8000; #1;
        check_eq("bltz.taken", 32'(BranchJumpTaken), 32'd1);
        check_eq("bltz.bpc", 32'(BranchPC), 32'h002E);
        RsData = 16'h7FFF; #1;
        check_eq("bltz_pos.taken", 32'(BranchJumpTaken), 32'd0);
        RsData = 16'h8000;

        // JR wrapping past 0xFFFF
        Instr = 16'h2A20; IncPC = 16'h0040;
        tick();
        check_eq("jr_sq.valid", 32'(IdValid), 32'd0);
        tick();
        check_eq("jr.instr", 32'(IdInstr), 32'h2A20);
        RsData = 16'hFFF0; #1;
        check_eq("jr.rsaddr", 32'(RsAddr), 32'd2);
        check_eq("jr.bpc", 32'(BranchPC), 32'h0010);
        check_eq("jr.taken", 32'(BranchJumpTaken), 32'd1);

        // J with negative displacement from PC+2=0
        Instr = 16'h27FF; IncPC = 16'h0000;
        tick();
        check_eq("j_sq.valid", 32'(IdValid), 32'd0);
        tick();
        check_eq("j.instr", 32'(IdInstr), 32'h27FF);
        check_eq("j.bpc", 32'(BranchPC), 32'hFFFF);
        check_ctrl("j", 1, 0, 0, 0, 0);

        // SIIC in RUN, SIIC in EXCPT, RTI in EXCPT, RTI in RUN
        Instr = 16'h1000; IncPC = 16'h0100;
        tick();
        tick();
        check_eq("siic.instr", 32'(IdInstr), 32'h1000);
        check_ctrl("siic", 0, 0, 0, 1, 0);
        tick();
        check_eq("siic_sq.valid", 32'(IdValid), 32'd0);
        check_ctrl("siic_sq", 0, 0, 0, 0, 0);
        tick();
        check_eq("siic2.valid", 32'(IdValid), 32'd1);
        check_ctrl("siic2", 0, 0, 0, 0, 0);
        Instr = 16'h1800;
        tick();
        check_eq("rti.valid", 32'(IdValid), 32'd1);
        check_eq("rti.instr", 32'(IdInstr), 32'h1800);
        check_ctrl("rti", 0, 0, 1, 0, 0);
        tick();
        check_eq("rti_sq.valid", 32'(IdValid), 32'd0);
        tick();
        check_eq("rti2.valid", 32'(IdValid), 32'd1);
        check_ctrl("rti2", 0, 0, 0, 0, 0);

        // Reset from EXCPT returns to RUN: a fresh SIIC must pulse again
        Instr = 16'h1000;
        tick();
        check_eq("siic3.exc", 32'(Exception), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check_eq("post_rst.instr", 32'(IdInstr), 32'h1000);
        check_eq("post_rst.exc", 32'(Exception), 32'd1);
        tick();

        // Undefined opcode passes with no redirect
        Instr = 16'hF8FF; RsData = 16'h0000;
        tick();
        check_eq("undef.instr", 32'(IdInstr), 32'hF8FF);
        check_ctrl("undef", 0, 0, 0, 0, 0);
        Instr = 16'h0000;
        tick();
        check_eq("undef_next.valid", 32'(IdValid), 32'd1);

        // HALT and the sticky HALTED state
        check_eq("halt.instr", 32'(IdInstr), 32'h0000);
        check_ctrl("halt", 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            Instr = (i % 2 == 0) ? 16'h27FF : 16'h1000;
            tick();
            check_eq("halted.valid", 32'(IdValid), 32'd0);
            check_ctrl("halted", 0, 1, 0, 0, 1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_ctrl("halt_rst", 0, 0, 0, 0, 0);

`ifdef CFU_STATS_EN
        check_eq("stats_rst.taken", 32'(TakenCount), 32'd0);
        check_eq("stats_rst.squash", 32'(SquashCount), 32'd0);
        Instr = 16'h27FF;
        tick();
        check_eq("stats_j.taken", 32'(TakenCount), 32'd0);
        tick();
        check_eq("stats_1.taken", 32'(TakenCount), 32'd1);
        check_eq("stats_1.squash", 32'(SquashCount), 32'd1);
        for (int i = 0; i < 40; i++) tick();
        check_eq("stats_sat.taken", 32'(TakenCount), 32'hF);
        check_eq("stats_sat.squash", 32'(SquashCount), 32'hF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
